// File: rtl/adc_pkg.sv
// Shared types for the ADC sample path: sample type, default FIFO depth and
// the status word the register block reads back.
package adc_pkg;

  typedef logic signed [7:0] sample_t;

  localparam int ADC_FIFO_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [$clog2(ADC_FIFO_DEPTH_DEFAULT):0] count;
    logic                                    empty;
    logic                                    full;
    logic                                    overflow;
    logic                                    underflow;
  } fifo_status_t;

endpackage

// File: rtl/adc_sample_fifo.sv
// Sample FIFO between the FIR datapath and the I2C register block.
// Optional watermark interrupt enabled by defining ADC_SAMPLE_FIFO_WATERMARK_EN.
module adc_sample_fifo
  import adc_pkg::*;
#(
  parameter int DEPTH     = ADC_FIFO_DEPTH_DEFAULT,
  parameter int DW        = $bits(sample_t),
  parameter bit OVERWRITE = 1'b0,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_req,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
`ifdef ADC_SAMPLE_FIFO_WATERMARK_EN
  ,
  input  logic [CW-1:0] watermark,
  output logic          wm_irq
`endif
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          pop, push, discard, mem_we;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_comb begin
    pop        = rd_req && !empty;
    // Full with no pop: drop the sample, or in overwrite mode evict the oldest.
    discard    = OVERWRITE && wr_valid && full && !rd_req;
    push       = wr_valid && (!full || rd_req || OVERWRITE);
    mem_we     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      mem_we = push;
      if (pop) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      if (pop || discard) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push)           wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop || discard);
      if (wr_valid && full && !rd_req) ovf_d = 1'b1;
      if (rd_req && empty)             udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is not reset; entries are unreachable while count is zero.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

`ifdef ADC_SAMPLE_FIFO_WATERMARK_EN
  logic wm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    wm_q <= 1'b0;
    else if (clr) wm_q <= 1'b0;
    else          wm_q <= (watermark != '0) && (count_q >= watermark);
  end

  assign wm_irq = wm_q;
`endif

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Bench for adc_sample_fifo: a drop-policy and an overwrite-policy instance
// share one stimulus stream and are compared against a queue model.
module tb_adc_sample_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int WM    = 2;

  logic clk;
  logic reset;
  logic clr;
  logic wr_valid;
  logic [7:0] wr_data;
  logic rd_req;

  logic [7:0]    o_rd_data  [2];
  logic          o_rd_valid [2];
  logic [CW-1:0] o_count    [2];
  logic          o_empty    [2];
  logic          o_full     [2];
  logic          o_ovf      [2];
  logic          o_udf      [2];

  logic [7:0] m_rd_data  [2];
  logic       m_rd_valid [2];
  logic       m_ovf      [2];
  logic       m_udf      [2];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

`ifdef ADC_SAMPLE_FIFO_WATERMARK_EN
  logic [CW-1:0] watermark;
  logic          o_wm [2];
  logic          m_wm [2];
  assign watermark = CW'(WM);
`endif

  int n_pass;
  int n_total;

  adc_sample_fifo #(.DEPTH(DEPTH), .DW(8), .OVERWRITE(1'b0)) u_drop (
    .clk(clk), .reset(reset), .clr(clr),
    .wr_valid(wr_valid), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(o_rd_data[0]), .rd_valid(o_rd_valid[0]), .count(o_count[0]),
    .empty(o_empty[0]), .full(o_full[0]),
    .overflow(o_ovf[0]), .underflow(o_udf[0])
`ifdef ADC_SAMPLE_FIFO_WATERMARK_EN
    , .watermark(watermark), .wm_irq(o_wm[0])
`endif
  );

  adc_sample_fifo #(.DEPTH(DEPTH), .DW(8), .OVERWRITE(1'b1)) u_ovwr (
    .clk(clk), .reset(reset), .clr(clr),
    .wr_valid(wr_valid), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(o_rd_data[1]), .rd_valid(o_rd_valid[1]), .count(o_count[1]),
    .empty(o_empty[1]), .full(o_full[1]),
    .overflow(o_ovf[1]), .underflow(o_udf[1])
`ifdef ADC_SAMPLE_FIFO_WATERMARK_EN
    , .watermark(watermark), .wm_irq(o_wm[1])
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_rd_data[i]  = '0;
      m_rd_valid[i] = 1'b0;
      m_ovf[i]      = 1'b0;
      m_udf[i]      = 1'b0;
`ifdef ADC_SAMPLE_FIFO_WATERMARK_EN
      m_wm[i]       = 1'b0;
`endif
    end
  endtask

  // One clock edge of the reference model: clr wins, then pop, then push.
  task automatic model_edge(input bit wr, input logic [7:0] d, input bit rd, input bit c);
    logic [7:0] q[$];
    int pre;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) q = exp_q0; else q = exp_q1;
      pre = q.size();
      m_rd_valid[i] = 1'b0;
      if (c) begin
        q.delete();
        m_ovf[i] = 1'b0;
        m_udf[i] = 1'b0;
`ifdef ADC_SAMPLE_FIFO_WATERMARK_EN
        m_wm[i]  = 1'b0;
`endif
      end else begin
`ifdef ADC_SAMPLE_FIFO_WATERMARK_EN
        m_wm[i] = (pre >= WM);
`endif
        if (rd) begin
          if (pre > 0) begin
            m_rd_data[i]  = q.pop_front();
            m_rd_valid[i] = 1'b1;
          end else begin
            m_udf[i] = 1'b1;
          end
        end
        if (wr) begin
          if (q.size() < DEPTH) begin
            q.push_back(d);
          end else begin
            m_ovf[i] = 1'b1;
            if (i == 1) begin
              void'(q.pop_front());
              q.push_back(d);
            end
          end
        end
      end
      if (i == 0) exp_q0 = q; else exp_q1 = q;
    end
  endtask

  task automatic check_all(input string where);
    int sz;
    for (int i = 0; i < 2; i++) begin
      sz = (i == 0) ? exp_q0.size() : exp_q1.size();
      chk($sformatf("%s u%0d rd_valid", where, i), o_rd_valid[i], m_rd_valid[i]);
      chk($sformatf("%s u%0d rd_data", where, i), o_rd_data[i], m_rd_data[i]);
      chk($sformatf("%s u%0d count", where, i), o_count[i], sz);
      chk($sformatf("%s u%0d empty", where, i), o_empty[i], sz == 0);
      chk($sformatf("%s u%0d full", where, i), o_full[i], sz == DEPTH);
      chk($sformatf("%s u%0d overflow", where, i), o_ovf[i], m_ovf[i]);
      chk($sformatf("%s u%0d underflow", where, i), o_udf[i], m_udf[i]);
`ifdef ADC_SAMPLE_FIFO_WATERMARK_EN
      chk($sformatf("%s u%0d wm_irq", where, i), o_wm[i], m_wm[i]);
`endif
    end
  endtask

  // Driver: inputs change on the falling edge, outputs checked 1ns after rise.
  task automatic step(input string where, input bit wr, input logic [7:0] d,
                      input bit rd, input bit c);
    @(negedge clk);
    wr_valid = wr;
    wr_data  = d;
    rd_req   = rd;
    clr      = c;
    @(posedge clk);
    model_edge(wr, d, rd, c);
    #1;
    check_all(where);
  endtask

  task automatic idle(input string where);
    step(where, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b1;
    clr      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) idle("idle");

    // Signed extremes round-trip in order
    step("push", 1'b1, 8'hFD, 1'b0, 1'b0);
    step("push", 1'b1, 8'h05, 1'b0, 1'b0);
    step("push", 1'b1, 8'h7F, 1'b0, 1'b0);
    step("push", 1'b1, 8'h80, 1'b0, 1'b0);
    repeat (4) begin
      step("pop", 1'b0, 8'h00, 1'b1, 1'b0);
      idle("pop_gap");
    end

    // Overflow: drop vs overwrite policy
    for (int v = 1; v <= 4; v++) step("fill", 1'b1, 8'(v), 1'b0, 1'b0);
    step("ovf_push", 1'b1, 8'd9, 1'b0, 1'b0);
    repeat (4) step("ovf_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow, then clr clears both flags
    step("udf_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    idle("udf_hold");
    step("clr", 1'b0, 8'h00, 1'b0, 1'b1);
    step("empty_rd_wr", 1'b1, 8'h42, 1'b1, 1'b0);
    step("clr_ignores", 1'b1, 8'h11, 1'b1, 1'b1);

    // Full with simultaneous push and pop, then pointer wrap
    for (int v = 1; v <= 4; v++) step("fill2", 1'b1, 8'(v), 1'b0, 1'b0);
    step("full_both", 1'b1, 8'd5, 1'b1, 1'b0);
    repeat (4) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step("wrap_push", 1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
      step("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Watermark ramp and asynchronous reset mid-stream
    for (int v = 0; v < 3; v++) step("pre_rst", 1'b1, 8'(8'h60 + v), 1'b0, 1'b0);
    idle("wm_high");
    step("wm_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    step("wm_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    idle("wm_low");
    step("pre_rst", 1'b1, 8'h70, 1'b0, 1'b0);
    step("pre_rst", 1'b1, 8'h71, 1'b1, 1'b0);
    @(negedge clk);
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    idle("post_rst");

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
    end
    idle("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
